// File: rtl/link_sdr_upstream_tx.sv
// Transmit side of the SDR link: buffers core words in a small FIFO and
// serializes each one LSB-first into channel-width beats, gated by credits
// that the downstream receiver hands back through token_i edges.
module link_sdr_upstream_tx #(
  parameter int width_p             = 32,
  parameter int channel_width_p     = 8,
  parameter int fifo_els_p          = 2,
  parameter int num_credits_p       = 16,
  parameter int credit_decimation_p = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [width_p-1:0]                 core_data_i,
  input  logic                               core_valid_i,
  output logic                               core_ready_o,
  output logic [channel_width_p-1:0]         io_data_o,
  output logic                               io_valid_o,
  input  logic                               token_i,
  output logic [$clog2(num_credits_p+1)-1:0] credit_cnt_o,
  output logic                               credit_err_o
);

  localparam int beats_lp  = width_p / channel_width_p;
  localparam int beat_w_lp = (beats_lp > 1) ? $clog2(beats_lp) : 1;
  localparam int ptr_w_lp  = $clog2(fifo_els_p);
  localparam int cnt_w_lp  = $clog2(fifo_els_p + 1);
  localparam int cred_w_lp = $clog2(num_credits_p + 1);
  localparam int ext_w_lp  = cred_w_lp + 2;

  localparam logic [0:0] st_idle = 1'b0;
  localparam logic [0:0] st_send = 1'b1;

  localparam logic [beat_w_lp-1:0] last_beat_lp    = beat_w_lp'(beats_lp - 1);
  localparam logic [ptr_w_lp-1:0]  last_ptr_lp     = ptr_w_lp'(fifo_els_p - 1);
  localparam logic [cnt_w_lp-1:0]  full_cnt_lp     = cnt_w_lp'(fifo_els_p);
  localparam logic [ext_w_lp-1:0]  max_cred_ext_lp = ext_w_lp'(num_credits_p);
  localparam logic [ext_w_lp-1:0]  dec_ext_lp      = ext_w_lp'(credit_decimation_p);
  localparam logic [ext_w_lp-1:0]  one_ext_lp      = ext_w_lp'(1);
  localparam logic [cred_w_lp-1:0] max_cred_lp     = cred_w_lp'(num_credits_p);

  logic [width_p-1:0]         mem_q [fifo_els_p];
  logic [width_p-1:0]         mem_d [fifo_els_p];
  logic [ptr_w_lp-1:0]        wptr_q, wptr_d;
  logic [ptr_w_lp-1:0]        rptr_q, rptr_d;
  logic [cnt_w_lp-1:0]        count_q, count_d;
  logic [0:0]                 state_q, state_d;
  logic [beat_w_lp-1:0]       beat_q, beat_d;
  logic [width_p-1:0]         shift_q, shift_d;
  logic [channel_width_p-1:0] io_data_q, io_data_d;
  logic                       io_valid_q, io_valid_d;
  logic [cred_w_lp-1:0]       credit_q, credit_d;
  logic                       err_q, err_d;
  logic                       token_prev_q, token_prev_d;

  logic                       fifo_empty;
  logic                       fifo_full;
  logic                       enq;
  logic                       load;
  logic                       token_rise;
  logic [width_p-1:0]         head;
  logic [ext_w_lp-1:0]        credit_ext;

  // Next-state logic for the FIFO, serializer FSM and credit counter.
  always_comb begin
    mem_d        = mem_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    count_d      = count_q;
    state_d      = state_q;
    beat_d       = beat_q;
    shift_d      = shift_q;
    io_data_d    = io_data_q;
    io_valid_d   = io_valid_q;
    credit_d     = credit_q;
    err_d        = err_q;
    token_prev_d = token_i;
    load         = 1'b0;

    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == full_cnt_lp);
    enq        = core_valid_i & ~fifo_full;
    head       = mem_q[rptr_q];
    token_rise = token_i & ~token_prev_q;

    // IDLE only trusts the registered count; chaining off the last beat may
    // also spend a credit that is being returned in the very same cycle.
    case (state_q)
      st_idle: begin
        if (!fifo_empty && (credit_q != '0)) load = 1'b1;
      end
      st_send: begin
        if (beat_q == last_beat_lp) begin
          if (!fifo_empty && ((credit_q != '0) || token_rise)) begin
            load = 1'b1;
          end else begin
            state_d    = st_idle;
            io_valid_d = 1'b0;
          end
        end else begin
          io_data_d = shift_q[channel_width_p-1:0];
          shift_d   = shift_q >> channel_width_p;
          beat_d    = beat_q + 1'b1;
        end
      end
      default: state_d = st_idle;
    endcase

    if (load) begin
      state_d    = st_send;
      io_valid_d = 1'b1;
      io_data_d  = head[channel_width_p-1:0];
      shift_d    = head >> channel_width_p;
      beat_d     = '0;
      rptr_d     = (rptr_q == last_ptr_lp) ? '0 : rptr_q + 1'b1;
    end

    if (enq) begin
      mem_d[wptr_q] = core_data_i;
      wptr_d        = (wptr_q == last_ptr_lp) ? '0 : wptr_q + 1'b1;
    end

    case ({enq, load})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Never underflows: a load always has either a stored or a returning credit.
    credit_ext = {2'b00, credit_q} + (token_rise ? dec_ext_lp : '0) - (load ? one_ext_lp : '0);
    if (credit_ext > max_cred_ext_lp) begin
      credit_d = max_cred_lp;
      err_d    = 1'b1;
    end else begin
      credit_d = credit_ext[cred_w_lp-1:0];
    end
  end

  // State registers; reset drops any partial packet and refills the credits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < fifo_els_p; i++) mem_q[i] <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      state_q      <= st_idle;
      beat_q       <= '0;
      shift_q      <= '0;
      io_data_q    <= '0;
      io_valid_q   <= 1'b0;
      credit_q     <= max_cred_lp;
      err_q        <= 1'b0;
      token_prev_q <= 1'b0;
    end else begin
      mem_q        <= mem_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      state_q      <= state_d;
      beat_q       <= beat_d;
      shift_q      <= shift_d;
      io_data_q    <= io_data_d;
      io_valid_q   <= io_valid_d;
      credit_q     <= credit_d;
      err_q        <= err_d;
      token_prev_q <= token_prev_d;
    end
  end

  assign core_ready_o = ~fifo_full;
  assign io_data_o    = io_data_q;
  assign io_valid_o   = io_valid_q;
  assign credit_cnt_o = credit_q;
  assign credit_err_o = err_q;

endmodule

// File: tb/tb_link_sdr_upstream_tx.sv
// Directed bench for link_sdr_upstream_tx with default parameters
// (32-bit words, 8-bit beats, 2-entry FIFO, 16 credits, 4 per token).
module tb_link_sdr_upstream_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] core_data_i;
  logic        core_valid_i;
  logic        core_ready_o;
  logic [7:0]  io_data_o;
  logic        io_valid_o;
  logic        token_i;
  logic [4:0]  credit_cnt_o;
  logic        credit_err_o;

  int pass_cnt  = 0;
  int total_cnt = 0;

  link_sdr_upstream_tx #(
    .width_p(32),
    .channel_width_p(8),
    .fifo_els_p(2),
    .num_credits_p(16),
    .credit_decimation_p(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .core_data_i(core_data_i),
    .core_valid_i(core_valid_i),
    .core_ready_o(core_ready_o),
    .io_data_o(io_data_o),
    .io_valid_o(io_valid_o),
    .token_i(token_i),
    .credit_cnt_o(credit_cnt_o),
    .credit_err_o(credit_err_o)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Reset pulse; returns just after a falling edge with reset released.
  task automatic do_reset();
    core_valid_i = 1'b0;
    core_data_i  = '0;
    token_i      = 1'b0;
    rst_n        = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Offers one word and returns at the falling edge after it was taken.
  task automatic push_word(input logic [31:0] w);
    int n;
    n = 0;
    core_data_i  = w;
    core_valid_i = 1'b1;
    while (!core_ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      total_cnt++;
      $display("[TB] FAIL push_timeout: ready stayed %0b, required 1", core_ready_o);
    end
    @(negedge clk);
    core_valid_i = 1'b0;
  endtask

  // Outputs while reset is held.
  task automatic test_reset();
    rst_n        = 1'b0;
    core_valid_i = 1'b0;
    core_data_i  = '0;
    token_i      = 1'b0;
    @(negedge clk);
    total_cnt++; if (io_valid_o !== 1'b0) $display("[TB] FAIL reset_valid: got %0b required 0", io_valid_o); else pass_cnt++;
    total_cnt++; if (io_data_o !== 8'h00) $display("[TB] FAIL reset_data: got %h required 00", io_data_o); else pass_cnt++;
    total_cnt++; if (credit_cnt_o !== 5'd16) $display("[TB] FAIL reset_credit: got %0d required 16", credit_cnt_o); else pass_cnt++;
    total_cnt++; if (credit_err_o !== 1'b0) $display("[TB] FAIL reset_err: got %0b required 0", credit_err_o); else pass_cnt++;
    total_cnt++; if (core_ready_o !== 1'b1) $display("[TB] FAIL reset_ready: got %0b required 1", core_ready_o); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One word: two-cycle latency, then four LSB-first beats.
  task automatic test_single_word();
    logic [31:0] w;
    logic [7:0]  exp_b;
    w = 32'hDDCCBBAA;
    do_reset();
    core_data_i  = w;
    core_valid_i = 1'b1;
    total_cnt++; if (core_ready_o !== 1'b1) $display("[TB] FAIL single_ready: got %0b required 1", core_ready_o); else pass_cnt++;
    @(negedge clk);
    core_valid_i = 1'b0;
    total_cnt++; if (io_valid_o !== 1'b0) $display("[TB] FAIL single_latency: valid %0b one cycle after accept, required 0", io_valid_o); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      exp_b = 8'(w >> (8 * i));
      total_cnt++;
      if ({io_valid_o, io_data_o} !== {1'b1, exp_b})
        $display("[TB] FAIL single_beat%0d: got valid=%0b data=%h required valid=1 data=%h", i, io_valid_o, io_data_o, exp_b);
      else pass_cnt++;
      if (i == 0) begin
        total_cnt++; if (credit_cnt_o !== 5'd15) $display("[TB] FAIL single_credit: got %0d required 15", credit_cnt_o); else pass_cnt++;
      end
    end
    @(negedge clk);
    total_cnt++; if (io_valid_o !== 1'b0) $display("[TB] FAIL single_end: valid %0b after last beat, required 0", io_valid_o); else pass_cnt++;
  endtask

  // Six words offered continuously: 24 gap-free beats, ready backpressure.
  task automatic test_back_to_back();
    logic [31:0] words [6];
    logic [7:0]  exp_b;
    int          idx;
    int          beat_idx;
    logic        saw_low;
    idx      = 0;
    beat_idx = 0;
    saw_low  = 1'b0;
    do_reset();
    for (int k = 0; k < 6; k++) words[k] = 32'h10203040 + 32'(k) * 32'h01010101;
    for (int cyc = 0; cyc < 100 && beat_idx < 24; cyc++) begin
      @(negedge clk);
      if (beat_idx > 0 || io_valid_o) begin
        exp_b = 8'(words[beat_idx / 4] >> (8 * (beat_idx % 4)));
        total_cnt++;
        if ({io_valid_o, io_data_o} !== {1'b1, exp_b})
          $display("[TB] FAIL stream_beat%0d: got valid=%0b data=%h required valid=1 data=%h", beat_idx, io_valid_o, io_data_o, exp_b);
        else pass_cnt++;
        beat_idx++;
      end
      if (!core_ready_o) saw_low = 1'b1;
      if (idx < 6) begin
        core_valid_i = 1'b1;
        core_data_i  = words[idx];
        if (core_ready_o) idx++;
      end else begin
        core_valid_i = 1'b0;
      end
    end
    core_valid_i = 1'b0;
    total_cnt++; if (beat_idx != 24) $display("[TB] FAIL stream_count: saw %0d beats, required 24", beat_idx); else pass_cnt++;
    total_cnt++; if (saw_low !== 1'b1) $display("[TB] FAIL stream_backpressure: ready low seen=%0b, required 1", saw_low); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (io_valid_o !== 1'b0) $display("[TB] FAIL stream_end: valid %0b, required 0", io_valid_o); else pass_cnt++;
    total_cnt++; if (credit_cnt_o !== 5'd10) $display("[TB] FAIL stream_credit: got %0d required 10", credit_cnt_o); else pass_cnt++;
  endtask

  // Exhaust all credits, confirm a queued word stalls, then release it.
  task automatic test_credit_exhaust();
    logic saw_valid;
    do_reset();
    for (int k = 0; k < 16; k++) push_word(32'hA0000000 + 32'(k));
    repeat (24) @(negedge clk);
    total_cnt++; if (credit_cnt_o !== 5'd0) $display("[TB] FAIL exhaust_credit: got %0d required 0", credit_cnt_o); else pass_cnt++;
    total_cnt++; if (io_valid_o !== 1'b0) $display("[TB] FAIL exhaust_idle: valid %0b required 0", io_valid_o); else pass_cnt++;
    push_word(32'h44332211);
    saw_valid = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (io_valid_o) saw_valid = 1'b1;
    end
    total_cnt++; if (saw_valid !== 1'b0) $display("[TB] FAIL exhaust_stall: beat seen=%0b with no credit, required 0", saw_valid); else pass_cnt++;
    total_cnt++; if (credit_cnt_o !== 5'd0) $display("[TB] FAIL exhaust_hold: got %0d required 0", credit_cnt_o); else pass_cnt++;
    token_i = 1'b1;
    @(negedge clk);
    token_i = 1'b0;
    total_cnt++; if (credit_cnt_o !== 5'd4) $display("[TB] FAIL token_return: got %0d required 4", credit_cnt_o); else pass_cnt++;
    total_cnt++; if (io_valid_o !== 1'b0) $display("[TB] FAIL token_wait: valid %0b required 0", io_valid_o); else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({io_valid_o, io_data_o} !== {1'b1, 8'h11})
      $display("[TB] FAIL token_start: got valid=%0b data=%h required valid=1 data=11", io_valid_o, io_data_o);
    else pass_cnt++;
    total_cnt++; if (credit_cnt_o !== 5'd3) $display("[TB] FAIL token_consume: got %0d required 3", credit_cnt_o); else pass_cnt++;
    total_cnt++; if (credit_err_o !== 1'b0) $display("[TB] FAIL token_err: got %0b required 0", credit_err_o); else pass_cnt++;
    repeat (5) @(negedge clk);
  endtask

  // Token edge in the same cycle a packet starts with three credits left.
  task automatic test_same_cycle_return();
    do_reset();
    for (int k = 0; k < 13; k++) push_word(32'hB0000000 + 32'(k));
    repeat (24) @(negedge clk);
    total_cnt++; if (credit_cnt_o !== 5'd3) $display("[TB] FAIL same_pre: got %0d required 3", credit_cnt_o); else pass_cnt++;
    push_word(32'hA1B2C3D4);
    token_i = 1'b1;
    @(negedge clk);
    token_i = 1'b0;
    total_cnt++; if (credit_cnt_o !== 5'd6) $display("[TB] FAIL same_credit: got %0d required 6", credit_cnt_o); else pass_cnt++;
    total_cnt++;
    if ({io_valid_o, io_data_o} !== {1'b1, 8'hD4})
      $display("[TB] FAIL same_start: got valid=%0b data=%h required valid=1 data=d4", io_valid_o, io_data_o);
    else pass_cnt++;
    repeat (6) @(negedge clk);
  endtask

  // Return at full credit saturates and raises the sticky error.
  task automatic test_credit_overflow();
    do_reset();
    token_i = 1'b1;
    @(negedge clk);
    token_i = 1'b0;
    total_cnt++; if (credit_cnt_o !== 5'd16) $display("[TB] FAIL ovf_credit: got %0d required 16", credit_cnt_o); else pass_cnt++;
    total_cnt++; if (credit_err_o !== 1'b1) $display("[TB] FAIL ovf_err: got %0b required 1", credit_err_o); else pass_cnt++;
    repeat (4) @(negedge clk);
    total_cnt++; if (credit_err_o !== 1'b1) $display("[TB] FAIL ovf_sticky: got %0b required 1", credit_err_o); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (credit_err_o !== 1'b0) $display("[TB] FAIL ovf_clear: got %0b required 0", credit_err_o); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Asynchronous reset during beat 2 drops both the live and queued words.
  task automatic test_reset_mid_packet();
    logic       saw_valid;
    logic [7:0] exp_b;
    do_reset();
    push_word(32'h0D0C0B0A);
    push_word(32'h1D1C1B1A);
    @(negedge clk);
    @(negedge clk);
    total_cnt++;
    if ({io_valid_o, io_data_o} !== {1'b1, 8'h0C})
      $display("[TB] FAIL mid_beat2: got valid=%0b data=%h required valid=1 data=0c", io_valid_o, io_data_o);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (io_valid_o !== 1'b0) $display("[TB] FAIL mid_valid: got %0b required 0", io_valid_o); else pass_cnt++;
    total_cnt++; if (credit_cnt_o !== 5'd16) $display("[TB] FAIL mid_credit: got %0d required 16", credit_cnt_o); else pass_cnt++;
    total_cnt++; if (core_ready_o !== 1'b1) $display("[TB] FAIL mid_ready: got %0b required 1", core_ready_o); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    saw_valid = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (io_valid_o) saw_valid = 1'b1;
    end
    total_cnt++; if (saw_valid !== 1'b0) $display("[TB] FAIL mid_flush: stale beat seen=%0b required 0", saw_valid); else pass_cnt++;
    push_word(32'h44332211);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      exp_b = 8'(32'h44332211 >> (8 * i));
      total_cnt++;
      if ({io_valid_o, io_data_o} !== {1'b1, exp_b})
        $display("[TB] FAIL mid_restart%0d: got valid=%0b data=%h required valid=1 data=%h", i, io_valid_o, io_data_o, exp_b);
      else pass_cnt++;
    end
    total_cnt++; if (credit_cnt_o !== 5'd15) $display("[TB] FAIL mid_restart_credit: got %0d required 15", credit_cnt_o); else pass_cnt++;
    repeat (2) @(negedge clk);
  endtask

  // Scenario sequence.
  initial begin
    $display("[TB] starting link_sdr_upstream_tx bench");
    test_reset();
    test_single_word();
    test_back_to_back();
    test_credit_exhaust();
    test_same_cycle_return();
    test_credit_overflow();
    test_reset_mid_packet();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
